// File: rtl/data_type_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_type_pkg
//  Description : Shared types for the bfloat16 op-mux/arith cluster and its
//                request scheduler: op codes, bf16 field layout, scheduler
//                state encoding and an op-code validity helper.
//  Revision    : 1.0  - initial release
// ============================================================================
package data_type_pkg;

    // Op codes understood by the arithmetic cluster. Code 0 is the idle op.
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_DIV = 4'h4;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Scans the request vector
//                starting at ptr_i and wrapping; the first asserted request
//                wins.
//  Ports       : req_i   - request vector
//                ptr_i   - index with highest priority this cycle
//                gnt_o   - one-hot grant
//                idx_o   - binary index of the grant
//                any_o   - at least one request granted
//  Revision    : 1.0  - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // One extra bit so ptr + offset can exceed NUM_REQ-1 before wrapping.
    logic [IDX_W:0] w_pos;
    logic           w_found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && req_i[w_pos[IDX_W-1:0]]) begin
                w_found                  = 1'b1;
                idx_o                    = w_pos[IDX_W-1:0];
                gnt_o[w_pos[IDX_W-1:0]]  = 1'b1;
            end
        end
        any_o = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/bf16_op_sched.sv
`default_nettype none
// ============================================================================
//  Module      : bf16_op_sched
//  Description : Round-robin scheduler sharing one bf16 add/sub/mul/div
//                cluster among NUM_REQ requesters. One op in flight; the op
//                select and operands are held for the op's fixed latency,
//                then the result is returned to the originating requester.
//  Ports       : req_valid_i/req_ready_o      - per-requester request handshake
//                req_op_i/req_a_i/req_b_i     - flattened request payloads
//                resp_valid_o/resp_ready_i    - per-requester response handshake
//                resp_data_o/ovf_o/err_o      - shared response payload
//                op_o/op1_o/op2_o             - drive to the arith cluster
//                res_i/ovf_i                  - cluster result and overflow
//  Revision    : 1.0  - initial release
// ============================================================================
module bf16_op_sched
    import data_type_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*4-1:0]    req_op_i,
    input  logic [NUM_REQ*16-1:0]   req_a_i,
    input  logic [NUM_REQ*16-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]      resp_valid_o,
    input  logic [NUM_REQ-1:0]      resp_ready_i,
    output logic [15:0]             resp_data_o,
    output logic                    resp_ovf_o,
    output logic                    resp_err_o,
    output logic [3:0]              op_o,
    output logic [15:0]             op1_o,
    output logic [15:0]             op2_o,
    input  logic [15:0]             res_i,
    input  logic                    ovf_i
);

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_w = $clog2(DIV_LAT + 1);

    localparam logic [c_cnt_w-1:0] c_add_ld = c_cnt_w'(ADD_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_mul_ld = c_cnt_w'(MUL_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_div_ld = c_cnt_w'(DIV_LAT - 1);

    sched_state_e         r_state;
    logic [c_idx_w-1:0]   r_rr;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [3:0]           r_op;
    bf16_t                r_op1;
    bf16_t                r_op2;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [15:0]          r_data;
    logic                 r_ovf;
    logic                 r_err;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [c_idx_w-1:0]   w_gnt_idx;
    logic                 w_any;
    logic                 w_fire;
    logic                 w_resp_ack;
    logic [c_idx_w-1:0]   w_rr_next;
    logic [3:0]           w_sel_op;
    bf16_t                w_sel_a;
    bf16_t                w_sel_b;
    logic [c_cnt_w-1:0]   w_lat_ld;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (r_rr),
        .gnt_o   (w_gnt),
        .idx_o   (w_gnt_idx),
        .any_o   (w_any)
    );

    // Payload of the current winner, selected by the one-hot grant.
    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_op = req_op_i[i*4 +: 4];
                w_sel_a  = req_a_i[i*16 +: 16];
                w_sel_b  = req_b_i[i*16 +: 16];
            end
        end
    end

    // Counter preload is LAT-1 so that the first EXEC cycle counts as cycle 1.
    always_comb begin
        unique case (w_sel_op)
            OP_MUL:  w_lat_ld = c_mul_ld;
            OP_DIV:  w_lat_ld = c_div_ld;
            default: w_lat_ld = c_add_ld;
        endcase
    end

    assign w_fire     = (r_state == IDLE) && w_any;
    assign w_resp_ack = |(resp_ready_i & r_gnt);
    assign w_rr_next  = (w_gnt_idx == c_idx_w'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    assign req_ready_o  = (r_state == IDLE) ? w_gnt : '0;
    assign resp_valid_o = (r_state == RESP) ? r_gnt : '0;
    assign resp_data_o  = r_data;
    assign resp_ovf_o   = r_ovf;
    assign resp_err_o   = r_err;
    assign op_o         = r_op;
    assign op1_o        = r_op1;
    assign op2_o        = r_op2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_gnt   <= '0;
            r_op    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_gnt <= w_gnt;
                        r_rr  <= w_rr_next;
                        if (is_valid_op(w_sel_op)) begin
                            r_op    <= w_sel_op;
                            r_op1   <= w_sel_a;
                            r_op2   <= w_sel_b;
                            r_cnt   <= w_lat_ld;
                            r_err   <= 1'b0;
                            r_state <= EXEC;
                        end else begin
                            // Unsupported op: skip the cluster, cluster stays at op 0.
                            r_data  <= '0;
                            r_ovf   <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_data  <= res_i;
                        r_ovf   <= ovf_i;
                        r_op    <= '0;
                        r_op1   <= '0;
                        r_op2   <= '0;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (w_resp_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bf16_op_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bf16_op_sched
//  Description : Directed self-checking bench for bf16_op_sched with a
//                latency-aware model of the shared arithmetic cluster.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_bf16_op_sched;
    import data_type_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADD_LAT = 1;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [7:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b11;
    logic [15:0] resp_data;
    logic        resp_ovf;
    logic        resp_err;
    logic [3:0]  op;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] res;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    bit ovf_mode = 1'b0;
    int held = 0;
    logic [3:0]  prev_op = '0;
    logic [15:0] prev_a = '0;
    logic [15:0] prev_b = '0;

    always #5 clk = ~clk;

    bf16_op_sched #(
        .NUM_REQ (NUM_REQ),
        .ADD_LAT (ADD_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_ovf_o   (resp_ovf),
        .resp_err_o   (resp_err),
        .op_o         (op),
        .op1_o        (op1),
        .op2_o        (op2),
        .res_i        (res),
        .ovf_i        (ovf)
    );

    function automatic int lat_of(input logic [3:0] o);
        case (o)
            OP_ADD, OP_SUB: return ADD_LAT;
            OP_MUL:         return MUL_LAT;
            OP_DIV:         return DIV_LAT;
            default:        return 1;
        endcase
    endfunction

    // Cluster model: result only becomes correct once the op and operands
    // have been held unchanged for the op's latency.
    always @(negedge clk) begin
        if (op != 4'h0 && op == prev_op && op1 == prev_a && op2 == prev_b)
            held <= held + 1;
        else if (op != 4'h0)
            held <= 1;
        else
            held <= 0;
        prev_op <= op;
        prev_a  <= op1;
        prev_b  <= op2;
    end

    always_comb begin
        res = 16'hBAD0;
        ovf = 1'b0;
        if (op != 4'h0 && held >= lat_of(op)) begin
            if (ovf_mode) begin
                res = 16'h7F80;
                ovf = 1'b1;
            end else begin
                case (op)
                    OP_ADD:  res = (op1 == 16'h3F80 && op2 == 16'h4000) ? 16'h4040 : 16'hBAD1;
                    OP_MUL:  res = (op1 == 16'h4000 && op2 == 16'h4000) ? 16'h4080 : 16'hBAD1;
                    OP_DIV:  res = (op1 == 16'h4080 && op2 == 16'h4000) ? 16'h4000 : 16'hBAD1;
                    default: res = 16'hBAD1;
                endcase
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b required 00 00", req_ready, resp_valid);
        end
        checks++;
        if ({op, op1, op2, resp_data, resp_ovf, resp_err} !== '0) begin
            errors++;
            $display("FAIL reset_data: op=%h op1=%h op2=%h data=%h ovf=%b err=%b required all 0",
                     op, op1, op2, resp_data, resp_ovf, resp_err);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_add;
        req_valid   = 2'b01;
        req_op[3:0] = OP_ADD;
        req_a[15:0] = 16'h3F80;
        req_b[15:0] = 16'h4000;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL add_grant: ready=%b required 01", req_ready);
        end
        tick;
        req_valid = 2'b00;
        checks++;
        if ({op, op1, op2} !== {OP_ADD, 16'h3F80, 16'h4000}) begin
            errors++;
            $display("FAIL add_issue: op=%h op1=%h op2=%h required %h 3f80 4000", op, op1, op2, OP_ADD);
        end
        tick;
        checks++;
        if (resp_valid !== 2'b01 || resp_data !== 16'h4040 || resp_ovf !== 1'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL add_resp: valid=%b data=%h ovf=%b err=%b required 01 4040 0 0",
                     resp_valid, resp_data, resp_ovf, resp_err);
        end
        checks++;
        if (op !== 4'h0 || op1 !== 16'h0) begin
            errors++;
            $display("FAIL add_op_idle: op=%h op1=%h required 0 0", op, op1);
        end
        tick;
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL add_resp_done: valid=%b required 00", resp_valid);
        end
    endtask

    task automatic test_div_latency;
        req_valid    = 2'b10;
        req_op[7:4]  = OP_DIV;
        req_a[31:16] = 16'h4080;
        req_b[31:16] = 16'h4000;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL div_grant: ready=%b required 10", req_ready);
        end
        tick;
        req_valid = 2'b00;
        for (int k = 1; k <= DIV_LAT; k++) begin
            checks++;
            if ({op, op1, op2} !== {OP_DIV, 16'h4080, 16'h4000} || resp_valid !== 2'b00) begin
                errors++;
                $display("FAIL div_exec_c%0d: op=%h op1=%h op2=%h valid=%b required %h 4080 4000 00",
                         k, op, op1, op2, resp_valid, OP_DIV);
            end
            tick;
        end
        checks++;
        if (resp_valid !== 2'b10 || resp_data !== 16'h4000 || resp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL div_resp: valid=%b data=%h ovf=%b required 10 4000 0", resp_valid, resp_data, resp_ovf);
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        int n;
        req_valid = 2'b11;
        req_op    = {OP_MUL, OP_MUL};
        req_a     = {16'h4000, 16'h4000};
        req_b     = {16'h4000, 16'h4000};
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (req_ready == 2'b00 && n < 10) begin
                tick;
                n++;
            end
            checks++;
            if (req_ready !== exp || n !== 0) begin
                errors++;
                $display("FAIL rr_grant%0d: ready=%b after %0d idle cycles required %b after 0", k, req_ready, n, exp);
            end
            tick;
            n = 0;
            while (resp_valid == 2'b00 && n < 20) begin
                tick;
                n++;
            end
            checks++;
            if (resp_valid !== exp || resp_data !== 16'h4080 || n !== MUL_LAT) begin
                errors++;
                $display("FAIL rr_resp%0d: valid=%b data=%h lat=%0d required %b 4080 %0d",
                         k, resp_valid, resp_data, n, exp, MUL_LAT);
            end
            tick;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure;
        ovf_mode   = 1'b1;
        resp_ready = 2'b00;
        req_valid  = 2'b11;
        req_op     = {OP_ADD, OP_MUL};
        req_a      = {16'h3F80, 16'h7F00};
        req_b      = {16'h4000, 16'h7F00};
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_grant: ready=%b required 01", req_ready);
        end
        tick;
        req_valid = 2'b10;
        tick;
        tick;
        checks++;
        if (resp_valid !== 2'b01 || resp_data !== 16'h7F80 || resp_ovf !== 1'b1 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_resp: valid=%b data=%h ovf=%b err=%b required 01 7f80 1 0",
                     resp_valid, resp_data, resp_ovf, resp_err);
        end
        ovf_mode   = 1'b0;
        resp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++;
            if (resp_valid !== 2'b01 || resp_data !== 16'h7F80 || resp_ovf !== 1'b1 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h ovf=%b ready=%b required 01 7f80 1 00",
                         k, resp_valid, resp_data, resp_ovf, req_ready);
            end
        end
        resp_ready = 2'b11;
        tick;
        checks++;
        if (req_ready !== 2'b10 || resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b required 10 00", req_ready, resp_valid);
        end
        tick;
        req_valid = 2'b00;
        tick;
        checks++;
        if (resp_valid !== 2'b10 || resp_data !== 16'h4040 || resp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_next: valid=%b data=%h ovf=%b required 10 4040 0", resp_valid, resp_data, resp_ovf);
        end
        tick;
    endtask

    task automatic test_bad_op;
        req_valid   = 2'b01;
        req_op[3:0] = 4'hF;
        req_a[15:0] = 16'h1234;
        req_b[15:0] = 16'h5678;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bad_grant: ready=%b required 01", req_ready);
        end
        tick;
        req_valid = 2'b00;
        checks++;
        if (resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_data !== 16'h0 || resp_ovf !== 1'b0 || op !== 4'h0) begin
            errors++;
            $display("FAIL bad_resp: valid=%b err=%b data=%h ovf=%b op=%h required 01 1 0000 0 0",
                     resp_valid, resp_err, resp_data, resp_ovf, op);
        end
        tick;
    endtask

    task automatic test_reset_mid_op;
        req_valid   = 2'b01;
        req_op[3:0] = OP_DIV;
        req_a[15:0] = 16'h4080;
        req_b[15:0] = 16'h4000;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_grant: ready=%b required 01", req_ready);
        end
        tick;
        req_valid = 2'b00;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({op, op1, op2} !== '0 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: op=%h op1=%h op2=%h valid=%b ready=%b required all 0",
                     op, op1, op2, resp_valid, req_ready);
        end
        tick;
        tick;
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_op    = {OP_ADD, OP_ADD};
        req_a     = {16'h3F80, 16'h3F80};
        req_b     = {16'h4000, 16'h4000};
        #1;
        checks++;
        if (req_ready !== 2'b01 || resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL rst_regrant: ready=%b valid=%b required 01 00", req_ready, resp_valid);
        end
        tick;
        req_valid = 2'b00;
        tick;
        checks++;
        if (resp_valid !== 2'b01 || resp_data !== 16'h4040 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_resp: valid=%b data=%h err=%b required 01 4040 0",
                     resp_valid, resp_data, resp_err);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_single_add;
        test_div_latency;
        test_round_robin;
        test_backpressure;
        test_bad_op;
        test_reset_mid_op;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
